// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 8N1 UART pair (serial_t / serial_r).
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 1300;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Bit-period counter width: ceil(log2(clks)), never below one bit.
  function automatic int timer_width(input int clks);
    if (clks <= 2) return 1;
    return $clog2(clks);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module bit_timer import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int WIDTH        = timer_width(UART_CLKS_PER_BIT)
) (
  input  logic m_clock,
  input  logic p_reset,
  input  logic clear,
  output logic tick
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(CLKS_PER_BIT - 1);

  logic [WIDTH-1:0] count;

  assign tick = (count == LAST) && !clear;

  // Restarting on tick keeps every bit period exactly CLKS_PER_BIT cycles with no dead cycle.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/serial_t.sv
// UART 8N1 transmitter: start bit, 8 data bits LSB first, stop bit; registered TXD.
module serial_t import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 p_reset,
  input  logic                 m_clock,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send,
  output logic                 TXD,
  output logic                 busy,
  output logic                 done
);

  localparam int         TW       = timer_width(CLKS_PER_BIT);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 timer_clear;

  // Timer is held at zero while idle, so the start bit always gets a full period.
  assign timer_clear = (state == IDLE);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .WIDTH        (TW)
  ) u_bit_timer (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .clear   (timer_clear),
    .tick    (tick)
  );

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state     <= IDLE;
      TXD       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            shift_reg <= data;
            bit_idx   <= '0;
            state     <= START;
            TXD       <= 1'b0;
            busy      <= 1'b1;
          end else begin
            TXD  <= 1'b1;
            busy <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            TXD   <= shift_reg[0];
          end
        end
        DATA: begin
          // TXD is loaded with the next bit in the same edge that shifts, so bits abut.
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              TXD   <= 1'b1;
            end else begin
              TXD <= shift_reg[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          TXD   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
